// File: rtl/qm_seq_pkg.sv
// qm_seq_pkg: shared types, constants and step-decoding helpers for the
// sequenced quaternion multiplier.
package qm_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PIPE,
      DONE
   } state_t;

   localparam int STEP_W = 4;
   localparam logic [STEP_W-1:0] LAST_STEP = 4'd15;

   // Bit k set means product step k is subtracted from its accumulator.
   localparam logic [15:0] SUB_MASK = 16'h428E;

   // Term j of the current output selects a_j.
   function automatic logic [1:0] a_idx(input logic [STEP_W-1:0] s);
      return 2'(s);
   endfunction

   // Term j of output i pairs a_j with b_(j xor i).
   function automatic logic [1:0] b_idx(input logic [STEP_W-1:0] s);
      return s[1:0] ^ s[3:2];
   endfunction

endpackage

// File: rtl/qm_mul_core.sv
// qm_mul_core: combinational signed DATA_W x DATA_W multiplier with a full
// 2*DATA_W result.
module qm_mul_core #(
   parameter int DATA_W = 16
) (
   input  logic signed [DATA_W-1:0]   x,
   input  logic signed [DATA_W-1:0]   y,
   output logic signed [2*DATA_W-1:0] p
);

   logic signed [2*DATA_W-1:0] x_ext;
   logic signed [2*DATA_W-1:0] y_ext;

   assign x_ext = {{DATA_W{x[DATA_W-1]}}, x};
   assign y_ext = {{DATA_W{y[DATA_W-1]}}, y};
   assign p     = x_ext * y_ext;

endmodule

// File: rtl/qm_seq.sv
// qm_seq: quaternion Hamilton product q = a (x) b using one shared multiplier
// over 16 product steps, with valid/ready handshakes on both sides.
// Optional feature: define QM_SEQ_PIPE_MUL_EN to register the multiplier
// output; this adds a PIPE state and stretches latency from 16 to 17 edges.
module qm_seq #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 34
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] a0,
   input  logic signed [DATA_W-1:0] a1,
   input  logic signed [DATA_W-1:0] a2,
   input  logic signed [DATA_W-1:0] a3,
   input  logic signed [DATA_W-1:0] b0,
   input  logic signed [DATA_W-1:0] b1,
   input  logic signed [DATA_W-1:0] b2,
   input  logic signed [DATA_W-1:0] b3,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  q0,
   output logic signed [ACC_W-1:0]  q1,
   output logic signed [ACC_W-1:0]  q2,
   output logic signed [ACC_W-1:0]  q3,
   output logic                     busy
);

   import qm_seq_pkg::*;

   state_t                     state;
   state_t                     state_nxt;
   logic                       accept;
   logic [STEP_W-1:0]          step;
   logic signed [DATA_W-1:0]   a_r [4];
   logic signed [DATA_W-1:0]   b_r [4];
   logic signed [ACC_W-1:0]    acc [4];
   logic signed [DATA_W-1:0]   mul_x;
   logic signed [DATA_W-1:0]   mul_y;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic                       acc_en;
   logic [STEP_W-1:0]          acc_step;
   logic [1:0]                 acc_i;
   logic signed [ACC_W-1:0]    acc_prod;
   logic signed [ACC_W-1:0]    acc_upd;

   assign mul_x = a_r[a_idx(step)];
   assign mul_y = b_r[b_idx(step)];

   qm_mul_core #(.DATA_W(DATA_W)) u_mul (
      .x(mul_x),
      .y(mul_y),
      .p(prod)
   );

   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

`ifdef QM_SEQ_PIPE_MUL_EN
   logic signed [ACC_W-1:0] prod_r;
   logic [STEP_W-1:0]       pend_step;
   logic                    pend_valid;

   // Register each issued product so it is accumulated one cycle later; flush drops it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_r     <= '0;
         pend_step  <= '0;
         pend_valid <= 1'b0;
      end else if (flush) begin
         pend_valid <= 1'b0;
      end else begin
         prod_r     <= prod_ext;
         pend_step  <= step;
         pend_valid <= (state == RUN);
      end
   end

   assign acc_en   = pend_valid;
   assign acc_step = pend_step;
   assign acc_prod = prod_r;
`else
   assign acc_en   = (state == RUN);
   assign acc_step = step;
   assign acc_prod = prod_ext;
`endif

   assign acc_i   = acc_step[3:2];
   assign acc_upd = SUB_MASK[acc_step] ? (acc[acc_i] - acc_prod)
                                       : (acc[acc_i] + acc_prod);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; flush overrides every other transition.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !flush) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (step == LAST_STEP) begin
`ifdef QM_SEQ_PIPE_MUL_EN
               state_nxt = PIPE;
`else
               state_nxt = DONE;
`endif
            end
         end
         PIPE: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
      end
   end

   // Operand capture, step counter, accumulation and result commit on the last step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step <= '0;
         for (int k = 0; k < 4; k++) begin
            a_r[k] <= '0;
            b_r[k] <= '0;
            acc[k] <= '0;
         end
         q0 <= '0;
         q1 <= '0;
         q2 <= '0;
         q3 <= '0;
      end else if (flush) begin
         step <= '0;
      end else begin
         if (accept) begin
            a_r[0] <= a0;
            a_r[1] <= a1;
            a_r[2] <= a2;
            a_r[3] <= a3;
            b_r[0] <= b0;
            b_r[1] <= b1;
            b_r[2] <= b2;
            b_r[3] <= b3;
            for (int k = 0; k < 4; k++) begin
               acc[k] <= '0;
            end
            step <= '0;
         end
         if (state == RUN) begin
            step <= step + 1'b1;
         end
         if (acc_en) begin
            acc[acc_i] <= acc_upd;
            if (acc_step == LAST_STEP) begin
               q0 <= acc[0];
               q1 <= acc[1];
               q2 <= acc[2];
               q3 <= acc_upd;
            end
         end
      end
   end

endmodule
